// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared graphics constants, fill-rect FSM states and pixel packing
// Purpose : common definitions for the fill-rect generation engine and its clipper.
// Contents: screen/address defaults, pixel width, FSM state encoding, pack_pixel().
package gfx_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int ADDR_W_DEF   = 19;
  localparam int PIX_W        = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } gen_state_e;

  // 4:4:4 colour packed as {r,g,b}
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [3:0] r,
                                                   input logic [3:0] g,
                                                   input logic [3:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/fill_rect_clip.sv
// rtl/fill_rect_clip.sv - combinational screen clipping of a fill-rect command
// Purpose : derives exclusive end coordinates clipped to the screen and an empty flag.
// Ports   : i_origx/i_origy/i_wid/i_hgt (16b latched command fields)
//           o_x_end/o_y_end (17b exclusive clipped ends), o_empty (no pixels to draw)
module fill_rect_clip
  import gfx_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic [15:0] i_origx,
  input  logic [15:0] i_origy,
  input  logic [15:0] i_wid,
  input  logic [15:0] i_hgt,
  output logic [16:0] o_x_end,
  output logic [16:0] o_y_end,
  output logic        o_empty
);

  localparam logic [16:0] W_LIM = 17'(SCREEN_W);
  localparam logic [16:0] H_LIM = 17'(SCREEN_H);

  // 17-bit sums so origin+size never wraps before the clamp
  logic [16:0] w_sum_x;
  logic [16:0] w_sum_y;

  assign w_sum_x = {1'b0, i_origx} + {1'b0, i_wid};
  assign w_sum_y = {1'b0, i_origy} + {1'b0, i_hgt};

  assign o_x_end = (w_sum_x > W_LIM) ? W_LIM : w_sum_x;
  assign o_y_end = (w_sum_y > H_LIM) ? H_LIM : w_sum_y;

  assign o_empty = (i_wid == 16'd0) || (i_hgt == 16'd0) ||
                   ({1'b0, i_origx} >= W_LIM) || ({1'b0, i_origy} >= H_LIM);

endmodule

// File: rtl/fill_rect_gen_engine.sv
// rtl/fill_rect_gen_engine.sv - raster fill-rect pixel write generator
// Purpose : accepts one fill-rect command, clips it to the screen and emits one
//           framebuffer write per arbiter handshake, row by row, left to right.
// Ports   : clk, rst_ (async active-low)
//           cmd_rts/cmd_rtr + cmd_origx/origy/wid/hgt/r/g/b : command in
//           arb_rts/arb_rtr + arb_addr/arb_data              : pixel writes out
//           gen_busy (command in flight), gen_done (completion pulse)
module fill_rect_gen_engine
  import gfx_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              cmd_rts,
  output logic              cmd_rtr,
  input  logic [15:0]       cmd_origx,
  input  logic [15:0]       cmd_origy,
  input  logic [15:0]       cmd_wid,
  input  logic [15:0]       cmd_hgt,
  input  logic [3:0]        cmd_r,
  input  logic [3:0]        cmd_g,
  input  logic [3:0]        cmd_b,
  output logic              arb_rts,
  input  logic              arb_rtr,
  output logic [ADDR_W-1:0] arb_addr,
  output logic [PIX_W-1:0]  arb_data,
  output logic              gen_busy,
  output logic              gen_done
);

  localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(SCREEN_W);

  gen_state_e        r_state;
  gen_state_e        w_next_state;

  logic [15:0]       r_origx;
  logic [15:0]       r_origy;
  logic [15:0]       r_wid;
  logic [15:0]       r_hgt;
  logic [PIX_W-1:0]  r_color;
  logic [15:0]       r_x;
  logic [15:0]       r_y;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_arb_addr;
  logic [PIX_W-1:0]  r_arb_data;

  logic [16:0]       w_x_end;
  logic [16:0]       w_y_end;
  logic              w_empty;
  logic              w_cmd_xfc;
  logic              w_arb_xfc;
  logic              w_x_last;
  logic              w_last;
  logic [15:0]       w_x_inc;
  logic [ADDR_W-1:0] w_row0;

  fill_rect_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .i_origx (r_origx),
    .i_origy (r_origy),
    .i_wid   (r_wid),
    .i_hgt   (r_hgt),
    .o_x_end (w_x_end),
    .o_y_end (w_y_end),
    .o_empty (w_empty)
  );

  // Handshake-style outputs are pure state decodes, so reset forces them at once
  assign cmd_rtr  = (r_state == ST_IDLE);
  assign arb_rts  = (r_state == ST_EMIT);
  assign gen_busy = (r_state != ST_IDLE);
  assign gen_done = (r_state == ST_DONE);
  assign arb_addr = r_arb_addr;
  assign arb_data = r_arb_data;

  assign w_cmd_xfc = cmd_rts & cmd_rtr;
  assign w_arb_xfc = arb_rts & arb_rtr;
  assign w_x_inc   = r_x + 16'd1;
  assign w_x_last  = ({1'b0, r_x} == (w_x_end - 17'd1));
  assign w_last    = w_x_last && ({1'b0, r_y} == (w_y_end - 17'd1));
  // The only multiply: start-of-row address for the first row
  assign w_row0    = ADDR_W'(32'(r_origy) * 32'(SCREEN_W));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_xfc) w_next_state = ST_SETUP;
      ST_SETUP: w_next_state = w_empty ? ST_DONE : ST_EMIT;
      ST_EMIT:  if (w_arb_xfc && w_last) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_origx    <= '0;
      r_origy    <= '0;
      r_wid      <= '0;
      r_hgt      <= '0;
      r_color    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_arb_addr <= '0;
      r_arb_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_xfc) begin
            r_origx <= cmd_origx;
            r_origy <= cmd_origy;
            r_wid   <= cmd_wid;
            r_hgt   <= cmd_hgt;
            r_color <= pack_pixel(cmd_r, cmd_g, cmd_b);
          end
        end
        ST_SETUP: begin
          if (!w_empty) begin
            r_x        <= r_origx;
            r_y        <= r_origy;
            r_row_base <= w_row0;
            r_arb_addr <= w_row0 + ADDR_W'(r_origx);
            r_arb_data <= r_color;
          end
        end
        ST_EMIT: begin
          // Address is precomputed for the next pixel so it is registered and
          // already valid in the cycle after each accepted write (no bubbles)
          if (w_arb_xfc && !w_last) begin
            if (!w_x_last) begin
              r_x        <= w_x_inc;
              r_arb_addr <= r_row_base + ADDR_W'(w_x_inc);
            end else begin
              r_x        <= r_origx;
              r_y        <= r_y + 16'd1;
              r_row_base <= r_row_base + PITCH;
              r_arb_addr <= r_row_base + PITCH + ADDR_W'(r_origx);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_rect_gen_engine.sv
// tb/tb_fill_rect_gen_engine.sv - scoreboard testbench for fill_rect_gen_engine
module tb_fill_rect_gen_engine;

  localparam int SW = 640;
  localparam int SH = 480;

  logic        clk;
  logic        rst_;
  logic        cmd_rts;
  logic        cmd_rtr;
  logic [15:0] cmd_origx, cmd_origy, cmd_wid, cmd_hgt;
  logic [3:0]  cmd_r, cmd_g, cmd_b;
  logic        arb_rts;
  logic        arb_rtr;
  logic [18:0] arb_addr;
  logic [11:0] arb_data;
  logic        gen_busy;
  logic        gen_done;

  fill_rect_gen_engine dut (
    .clk       (clk),
    .rst_      (rst_),
    .cmd_rts   (cmd_rts),
    .cmd_rtr   (cmd_rtr),
    .cmd_origx (cmd_origx),
    .cmd_origy (cmd_origy),
    .cmd_wid   (cmd_wid),
    .cmd_hgt   (cmd_hgt),
    .cmd_r     (cmd_r),
    .cmd_g     (cmd_g),
    .cmd_b     (cmd_b),
    .arb_rts   (arb_rts),
    .arb_rtr   (arb_rtr),
    .arb_addr  (arb_addr),
    .arb_data  (arb_data),
    .gen_busy  (gen_busy),
    .gen_done  (gen_done)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [30:0] exp_q[$];
  int  n_writes   = 0;
  int  rts_cycles = 0;
  int  first_rts  = -1;
  int  done_cnt   = 0;
  int  done_cyc   = -1;
  int  xfc_cyc    = 0;
  logic toggle    = 1'b0;
  logic        stall_prev = 1'b0;
  logic [18:0] prev_addr;
  logic [11:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    arb_rtr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle) arb_rtr = ~arb_rtr;
      else        arb_rtr = 1'b1;
    end
  end

  // Monitor: compares each accepted write with the scoreboard head
  always @(negedge clk) begin
    if (!rst_) begin
      stall_prev = 1'b0;
    end else begin
      if (arb_rts) begin
        rts_cycles++;
        if (first_rts < 0) first_rts = cyc;
        if (stall_prev) begin
          chk("stall_addr", 32'(arb_addr), 32'(prev_addr));
          chk("stall_data", 32'(arb_data), 32'(prev_data));
        end
        if (arb_rtr) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(arb_addr), 32'hDEAD_BEEF);
          end else begin
            logic [30:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(arb_addr), 32'(e[18:0]));
            chk("wr_data", 32'(arb_data), 32'(e[30:19]));
          end
          n_writes++;
        end
        stall_prev = !arb_rtr;
        prev_addr  = arb_addr;
        prev_data  = arb_data;
      end else begin
        stall_prev = 1'b0;
      end
      if (gen_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_model(input int ox, input int oy, input int w, input int h,
                            input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    int xe, ye;
    logic [18:0] a;
    if (w == 0 || h == 0 || ox >= SW || oy >= SH) return;
    xe = (ox + w > SW) ? SW : ox + w;
    ye = (oy + h > SH) ? SH : oy + h;
    for (int y = oy; y < ye; y++)
      for (int x = ox; x < xe; x++) begin
        a = 19'(y * SW + x);
        exp_q.push_back({r, g, b, a});
      end
  endtask

  task automatic set_fields(input int ox, input int oy, input int w, input int h,
                            input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    cmd_origx = 16'(ox); cmd_origy = 16'(oy);
    cmd_wid   = 16'(w);  cmd_hgt   = 16'(h);
    cmd_r = r; cmd_g = g; cmd_b = b;
  endtask

  // Waits for acceptance; returns the cycle of the accepting edge's preceding negedge
  task automatic wait_accept(output int acc_cyc);
    int n = 0;
    acc_cyc = -1;
    while (n < 500) begin
      @(negedge clk);
      #1;
      if (cmd_rtr) begin
        acc_cyc = cyc;
        break;
      end
      n++;
    end
    chk("cmd_accept_seen", 32'(acc_cyc >= 0), 32'd1);
  endtask

  task automatic issue(input int ox, input int oy, input int w, input int h,
                       input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    push_model(ox, oy, w, h, r, g, b);
    first_rts  = -1;
    rts_cycles = 0;
    set_fields(ox, oy, w, h, r, g, b);
    cmd_rts = 1'b1;
    wait_accept(xfc_cyc);
    @(posedge clk);
    #1;
    cmd_rts = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt <= prev && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt), 32'(prev + 1));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_rtr"},  32'(cmd_rtr),  32'd1);
    chk({tag, "_arb_rts"},  32'(arb_rts),  32'd0);
    chk({tag, "_arb_addr"}, 32'(arb_addr), 32'd0);
    chk({tag, "_arb_data"}, 32'(arb_data), 32'd0);
    chk({tag, "_busy"},     32'(gen_busy), 32'd0);
    chk({tag, "_done"},     32'(gen_done), 32'd0);
  endtask

  initial begin
    int dc, w0, acc_b;
    rst_    = 1'b0;
    cmd_rts = 1'b0;
    set_fields(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic 3x2 rectangle, no backpressure
    dc = done_cnt; w0 = n_writes;
    issue(2, 3, 3, 2, 4'hF, 4'h0, 4'h8);
    chk("busy_after_accept", 32'(gen_busy), 32'd1);
    chk("rtr_after_accept",  32'(cmd_rtr),  32'd0);
    wait_done(dc);
    chk("t1_writes", 32'(n_writes - w0), 32'd6);
    chk("t1_latency", 32'(first_rts - xfc_cyc), 32'd2);
    chk("t1_rate", 32'(done_cyc - first_rts), 32'd6);
    chk("t1_rts_cycles", 32'(rts_cycles), 32'd6);

    // Same command with arb_rtr toggling every cycle
    toggle = 1'b1;
    dc = done_cnt; w0 = n_writes;
    issue(2, 3, 3, 2, 4'hF, 4'h0, 4'h8);
    wait_done(dc);
    chk("t2_writes", 32'(n_writes - w0), 32'd6);
    @(posedge clk);
    #1;
    toggle = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Clipped at bottom-right corner
    dc = done_cnt; w0 = n_writes;
    issue(638, 479, 5, 4, 4'h1, 4'h2, 4'h3);
    wait_done(dc);
    chk("t3_writes", 32'(n_writes - w0), 32'd2);
    chk("t3_rate", 32'(done_cyc - first_rts), 32'd2);

    // Empty: zero width
    dc = done_cnt; w0 = n_writes;
    issue(10, 10, 0, 5, 4'hA, 4'hB, 4'hC);
    wait_done(dc);
    chk("t4_rts_cycles", 32'(rts_cycles), 32'd0);
    chk("t4_done_lat", 32'(done_cyc - xfc_cyc), 32'd2);

    // Empty: origin off-screen
    dc = done_cnt; w0 = n_writes;
    issue(700, 10, 4, 4, 4'hA, 4'hB, 4'hC);
    wait_done(dc);
    chk("t4b_rts_cycles", 32'(rts_cycles), 32'd0);
    chk("t4b_done_lat", 32'(done_cyc - xfc_cyc), 32'd2);

    // Back-to-back commands with cmd_rts held high
    dc = done_cnt; w0 = n_writes;
    push_model(10, 10, 2, 2, 4'h5, 4'h6, 4'h7);
    push_model(20, 5, 3, 1, 4'h8, 4'h9, 4'hA);
    set_fields(10, 10, 2, 2, 4'h5, 4'h6, 4'h7);
    cmd_rts = 1'b1;
    wait_accept(xfc_cyc);
    @(posedge clk);
    #1;
    set_fields(20, 5, 3, 1, 4'h8, 4'h9, 4'hA);
    wait_accept(acc_b);
    chk("b2b_accept_gap", 32'(acc_b - done_cyc), 32'd1);
    chk("b2b_first_done", 32'(done_cnt), 32'(dc + 1));
    @(posedge clk);
    #1;
    cmd_rts = 1'b0;
    wait_done(dc + 1);
    chk("t5_writes", 32'(n_writes - w0), 32'd7);

    // Reset during the 3rd pixel of a 4x4
    w0 = n_writes;
    issue(0, 0, 4, 4, 4'h3, 4'hC, 4'h5);
    for (int n = 0; n < 100 && n_writes < w0 + 2; n++) begin
      @(negedge clk);
      #1;
    end
    chk("t6_pre_writes", 32'(n_writes - w0), 32'd2);
    @(posedge clk);
    #1;
    chk("t6_third_addr", 32'(arb_addr), 32'd2);
    rst_ = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    dc = done_cnt; w0 = n_writes;
    issue(100, 200, 2, 1, 4'h9, 4'h4, 4'h1);
    wait_done(dc);
    chk("t6_post_writes", 32'(n_writes - w0), 32'd2);
    chk("t6_post_latency", 32'(first_rts - xfc_cyc), 32'd2);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
